// File: rtl/record_table_arbiter_if.sv
// Bundles the write, read and control signals of record_table_arbiter.
// The master modport belongs to the producer/consumer side, the slave modport to the table.
interface record_table_arbiter_if #(
  parameter int AW = 3
);
  logic          init_start;
  logic          busy;
  logic          req0_valid;
  logic          req0_ready;
  logic [AW-1:0] req0_idx;
  logic [31:0]   req0_a;
  logic [31:0]   req0_b;
  logic          req1_valid;
  logic          req1_ready;
  logic [AW-1:0] req1_idx;
  logic [31:0]   req1_a;
  logic [31:0]   req1_b;
  logic          rd_en;
  logic [AW-1:0] rd_idx;
  logic          rd_valid;
  logic [31:0]   rd_a;
  logic [31:0]   rd_b;
  logic          err_oob;
  logic [15:0]   wr_count;

  modport master (
    output init_start, req0_valid, req0_idx, req0_a, req0_b,
    output req1_valid, req1_idx, req1_a, req1_b, rd_en, rd_idx,
    input  busy, req0_ready, req1_ready, rd_valid, rd_a, rd_b, err_oob, wr_count
  );

  modport slave (
    input  init_start, req0_valid, req0_idx, req0_a, req0_b,
    input  req1_valid, req1_idx, req1_a, req1_b, rd_en, rd_idx,
    output busy, req0_ready, req1_ready, rd_valid, rd_a, rd_b, err_oob, wr_count
  );
endinterface

// File: rtl/record_table_arbiter.sv
// DEPTH-entry table of {a,b} records: pattern fill, round-robin shared write port, registered reads.
// Optional RECTAB_TIMESTAMP_EN: field b of accepted writes takes a free-running cycle count.
module record_table_arbiter #(
  parameter int          DEPTH       = 8,
  parameter int          AW          = 3,
  parameter logic [31:0] DEFAULT_VAL = 32'd10
) (
  input logic             clk,
  input logic             rst_n,
  record_table_arbiter_if.slave bus
);
  typedef enum logic {S_FILL, S_RUN} state_t;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } rec_t;

  state_t        r_state, w_state_next;
  logic [AW-1:0] r_fill_ptr, w_fill_ptr_next;
  logic          r_last_grant, w_last_grant_next;
  logic [15:0]   r_wr_count, w_wr_count_next;
  logic          w_ready0, w_ready1, w_xfer, w_fill_we;
  logic          w_wr_oob, w_rd_oob;
  logic [AW-1:0] w_wr_idx;
  logic [31:0]   w_b0, w_b1;
  rec_t          w_wr_rec;
  rec_t          r_mem [DEPTH];
  rec_t          r_rd;
  logic          r_rd_valid, r_err_oob;

`ifdef RECTAB_TIMESTAMP_EN
  logic [31:0] r_cycle;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cycle <= '0;
    else        r_cycle <= r_cycle + 32'd1;
  end
  assign w_b0 = r_cycle;
  assign w_b1 = r_cycle;
`else
  assign w_b0 = bus.req0_b;
  assign w_b1 = bus.req1_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FILL;
      r_fill_ptr   <= '0;
      r_last_grant <= 1'b1;
      r_wr_count   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_fill_ptr   <= w_fill_ptr_next;
      r_last_grant <= w_last_grant_next;
      r_wr_count   <= w_wr_count_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_fill_ptr_next   = r_fill_ptr;
    w_last_grant_next = r_last_grant;
    w_wr_count_next   = r_wr_count;
    w_ready0          = 1'b0;
    w_ready1          = 1'b0;
    w_fill_we         = 1'b0;
    case (r_state)
      S_FILL: begin
        w_fill_we = 1'b1;
        if (bus.init_start) begin
          w_fill_ptr_next = '0;
        end else if (r_fill_ptr == AW'(DEPTH - 1)) begin
          w_state_next    = S_RUN;
          w_fill_ptr_next = '0;
        end else begin
          w_fill_ptr_next = r_fill_ptr + AW'(1);
        end
      end
      S_RUN: begin
        if (bus.init_start) begin
          w_state_next    = S_FILL;
          w_fill_ptr_next = '0;
          w_wr_count_next = '0;
        end else begin
          // last_grant==1 means requester 1 won most recently, so requester 0 has priority
          w_ready0 = bus.req0_valid & (~bus.req1_valid | r_last_grant);
          w_ready1 = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
          if (w_ready0)      w_last_grant_next = 1'b0;
          else if (w_ready1) w_last_grant_next = 1'b1;
          if ((w_ready0 | w_ready1) && r_wr_count != 16'hFFFF)
            w_wr_count_next = r_wr_count + 16'd1;
        end
      end
      default: w_state_next = S_FILL;
    endcase
  end

  assign w_xfer   = w_ready0 | w_ready1;
  assign w_wr_idx = w_ready0 ? bus.req0_idx : bus.req1_idx;
  assign w_wr_rec = w_ready0 ? {bus.req0_a, w_b0} : {bus.req1_a, w_b1};

  // A power-of-two table can never see an out-of-range index
  generate
    if (DEPTH == (1 << AW)) begin : g_no_oob
      assign w_wr_oob = 1'b0;
      assign w_rd_oob = 1'b0;
    end else begin : g_oob
      assign w_wr_oob = (32'(w_wr_idx) >= 32'(DEPTH));
      assign w_rd_oob = (32'(bus.rd_idx) >= 32'(DEPTH));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_fill_we)
      r_mem[r_fill_ptr] <= {DEFAULT_VAL, DEFAULT_VAL};
    else if (w_xfer && !w_wr_oob)
      r_mem[w_wr_idx] <= w_wr_rec;
  end

  // Nonblocking read of r_mem gives read-before-write on a same-index collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd       <= '0;
      r_err_oob  <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      r_err_oob  <= (w_xfer & w_wr_oob) | (bus.rd_en & w_rd_oob);
      if (bus.rd_en)
        r_rd <= w_rd_oob ? '0 : r_mem[bus.rd_idx];
    end
  end

  assign bus.busy       = (r_state == S_FILL);
  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_a       = r_rd.a;
  assign bus.rd_b       = r_rd.b;
  assign bus.err_oob    = r_err_oob;
  assign bus.wr_count   = r_wr_count;
endmodule

// File: tb/tb_record_table_arbiter.sv
// Scoreboard bench for record_table_arbiter: an 8-entry table for the main tests,
// a 6-entry table for out-of-range handling.
module tb_record_table_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  record_table_arbiter_if #(.AW(3)) b8 ();
  record_table_arbiter_if #(.AW(3)) b6 ();

  record_table_arbiter #(.DEPTH(8), .AW(3), .DEFAULT_VAL(32'd10)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(b8)
  );
  record_table_arbiter #(.DEPTH(6), .AW(3), .DEFAULT_VAL(32'd10)) dut6 (
    .clk(clk), .rst_n(rst_n), .bus(b6)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        oob;
  } exp_t;

  exp_t        q8[$];
  exp_t        q6[$];
  logic [31:0] m_a[8];
  logic [31:0] m_b[8];
  logic [31:0] tb_cyc;
  int          n_vec = 0;
  int          n_miss = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon8
    exp_t e;
    if (b8.rd_valid) begin
      if (q8.size() == 0) begin
        check("rd8_spurious", 64'(b8.rd_valid), 64'd0);
      end else begin
        e = q8.pop_front();
        $display("rd8 a=%0d b=%0d oob=%0b (exp a=%0d b=%0d oob=%0b)",
                 b8.rd_a, b8.rd_b, b8.err_oob, e.a, e.b, e.oob);
        check("rd8_a", 64'(b8.rd_a), 64'(e.a));
        check("rd8_b", 64'(b8.rd_b), 64'(e.b));
        check("rd8_oob", 64'(b8.err_oob), 64'(e.oob));
      end
    end
  end

  always @(negedge clk) begin : mon6
    exp_t e;
    if (b6.rd_valid) begin
      if (q6.size() == 0) begin
        check("rd6_spurious", 64'(b6.rd_valid), 64'd0);
      end else begin
        e = q6.pop_front();
        $display("rd6 a=%0d b=%0d oob=%0b (exp a=%0d b=%0d oob=%0b)",
                 b6.rd_a, b6.rd_b, b6.err_oob, e.a, e.b, e.oob);
        check("rd6_a", 64'(b6.rd_a), 64'(e.a));
        check("rd6_b", 64'(b6.rd_b), 64'(e.b));
        check("rd6_oob", 64'(b6.err_oob), 64'(e.oob));
      end
    end
  end

  task automatic op8(input logic v0, input logic [2:0] i0, input logic [31:0] a0, input logic [31:0] bb0,
                     input logic v1, input logic [2:0] i1, input logic [31:0] a1, input logic [31:0] bb1,
                     input logic re, input logic [2:0] ri, input logic init,
                     output logic rdy0, output logic rdy1);
    @(posedge clk); #1;
    b8.req0_valid = v0; b8.req0_idx = i0; b8.req0_a = a0; b8.req0_b = bb0;
    b8.req1_valid = v1; b8.req1_idx = i1; b8.req1_a = a1; b8.req1_b = bb1;
    b8.rd_en = re; b8.rd_idx = ri; b8.init_start = init;
    if (re) q8.push_back('{a: m_a[ri], b: m_b[ri], oob: 1'b0});
    @(negedge clk);
    rdy0 = b8.req0_ready;
    rdy1 = b8.req1_ready;
    if (v0 && rdy0) begin
      m_a[i0] = a0;
`ifdef RECTAB_TIMESTAMP_EN
      m_b[i0] = tb_cyc;
`else
      m_b[i0] = bb0;
`endif
    end else if (v1 && rdy1) begin
      m_a[i1] = a1;
`ifdef RECTAB_TIMESTAMP_EN
      m_b[i1] = tb_cyc;
`else
      m_b[i1] = bb1;
`endif
    end
    if (init) begin
      for (int k = 0; k < 8; k++) begin
        m_a[k] = 32'd10;
        m_b[k] = 32'd10;
      end
    end
  endtask

  task automatic idle8();
    logic r0, r1;
    op8(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  task automatic rd8(input logic [2:0] idx);
    logic r0, r1;
    op8(0, 0, 0, 0, 0, 0, 0, 0, 1, idx, 0, r0, r1);
  endtask

  task automatic op6(input logic v0, input logic [2:0] i0, input logic [31:0] a0,
                     input logic re, input logic [2:0] ri, output logic rdy0);
    @(posedge clk); #1;
    b6.req0_valid = v0; b6.req0_idx = i0; b6.req0_a = a0; b6.req0_b = a0 + 32'd1;
    b6.rd_en = re; b6.rd_idx = ri;
    if (re) begin
      if (ri >= 3'd6) q6.push_back('{a: 32'd0, b: 32'd0, oob: 1'b1});
      else            q6.push_back('{a: 32'd10, b: 32'd10, oob: 1'b0});
    end
    @(negedge clk);
    rdy0 = b6.req0_ready;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r0, r1;
    int   cnt;
    for (int k = 0; k < 8; k++) begin
      m_a[k] = 32'd10;
      m_b[k] = 32'd10;
    end
    b8.init_start = 0; b8.req0_valid = 1; b8.req0_idx = 0; b8.req0_a = 0; b8.req0_b = 0;
    b8.req1_valid = 1; b8.req1_idx = 0; b8.req1_a = 0; b8.req1_b = 0; b8.rd_en = 0; b8.rd_idx = 0;
    b6.init_start = 0; b6.req0_valid = 0; b6.req0_idx = 0; b6.req0_a = 0; b6.req0_b = 0;
    b6.req1_valid = 0; b6.req1_idx = 0; b6.req1_a = 0; b6.req1_b = 0; b6.rd_en = 0; b6.rd_idx = 0;

    // Reset state, with both requesters pushing
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(b8.busy), 64'd1);
    check("rst_ready0", 64'(b8.req0_ready), 64'd0);
    check("rst_ready1", 64'(b8.req1_ready), 64'd0);
    check("rst_rd_valid", 64'(b8.rd_valid), 64'd0);
    check("rst_rd_a", 64'(b8.rd_a), 64'd0);
    check("rst_rd_b", 64'(b8.rd_b), 64'd0);
    check("rst_err_oob", 64'(b8.err_oob), 64'd0);
    check("rst_wr_count", 64'(b8.wr_count), 64'd0);
    b8.req0_valid = 0;
    b8.req1_valid = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Initial fill lasts exactly DEPTH cycles, then every entry holds 10/10
    cnt = 0;
    @(negedge clk);
    while (b8.busy && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("fill_cycles", 64'(cnt), 64'd8);
    for (int i = 0; i < 8; i++) rd8(3'(i));
    idle8();

    // Contention: requester 0 wins first, then requester 1
    op8(1, 3, 42, 29, 1, 4, 5, 7, 0, 0, 0, r0, r1);
    check("arb1_ready0", 64'(r0), 64'd1);
    check("arb1_ready1", 64'(r1), 64'd0);
    op8(1, 3, 42, 29, 1, 4, 5, 7, 0, 0, 0, r0, r1);
    check("arb2_ready0", 64'(r0), 64'd0);
    check("arb2_ready1", 64'(r1), 64'd1);
    op8(0, 0, 0, 0, 1, 5, 77, 78, 0, 0, 0, r0, r1);
    check("solo1_ready1", 64'(r1), 64'd1);
    check("solo1_ready0", 64'(r0), 64'd0);
    idle8();
    check("wr_count_3", 64'(b8.wr_count), 64'd3);
    rd8(3); rd8(4); rd8(5);

    // Same-cycle write and read of index 2 returns the old value
    op8(1, 2, 1, 3, 0, 0, 0, 0, 1, 2, 0, r0, r1);
    check("rbw_ready0", 64'(r0), 64'd1);
    rd8(2);
    idle8(); idle8(); idle8();
    check("hold_rd_a", 64'(b8.rd_a), 64'd1);
    check("hold_rd_valid", 64'(b8.rd_valid), 64'd0);
    check("wr_count_4", 64'(b8.wr_count), 64'd4);

    // init_start in RUN blocks the pending request and refills the table
    op8(1, 3, 99, 98, 0, 0, 0, 0, 0, 0, 1, r0, r1);
    check("init_ready0", 64'(r0), 64'd0);
    cnt = 0;
    idle8();
    while (b8.busy && cnt < 20) begin
      cnt++;
      idle8();
    end
    check("refill_cycles", 64'(cnt), 64'd8);
    check("refill_wr_count", 64'(b8.wr_count), 64'd0);
    rd8(3); rd8(2);
    idle8();

    // 6-entry table: index 7 is out of range
    op6(1, 7, 5, 0, 0, r0);
    check("oob_wr_ready", 64'(r0), 64'd1);
    op6(0, 0, 0, 0, 0, r0);
    check("oob_err_pulse", 64'(b6.err_oob), 64'd1);
    check("oob_wr_count", 64'(b6.wr_count), 64'd1);
    op6(0, 0, 0, 0, 0, r0);
    check("oob_err_clear", 64'(b6.err_oob), 64'd0);
    op6(0, 0, 0, 1, 7, r0);
    op6(0, 0, 0, 1, 5, r0);
    op6(0, 0, 0, 0, 0, r0);
    op6(0, 0, 0, 0, 0, r0);

    check("q8_drained", 64'(q8.size()), 64'd0);
    check("q6_drained", 64'(q6.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
